// File: rtl/ys_poly_small_ctrl3_pkg.sv
// Shared constants, FSM encoding and sizing helper for the ys_poly_small mode controllers.
package ys_poly_small_ctrl3_pkg;

  localparam int unsigned NtruN = 509;
  localparam int unsigned DefAw = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic int unsigned ceil_half(input int unsigned x);
    return (x + 1) / 2;
  endfunction

endpackage

// File: rtl/ys_poly_small_wpipe.sv
// Depth-stage delay line carrying per-port write valids and addresses to the RAM2 write side.
module ys_poly_small_wpipe #(
  parameter int unsigned Depth = 2,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          va_i,
  input  logic          vb_i,
  input  logic [AW-1:0] addra_i,
  input  logic [AW-1:0] addrb_i,
  output logic          wea_o,
  output logic          web_o,
  output logic [AW-1:0] addra_o,
  output logic [AW-1:0] addrb_o
);

  logic [Depth-1:0] va_q, va_d, vb_q, vb_d;
  logic [AW-1:0]    addra_q [Depth];
  logic [AW-1:0]    addra_d [Depth];
  logic [AW-1:0]    addrb_q [Depth];
  logic [AW-1:0]    addrb_d [Depth];

  // Addresses only advance alongside a valid, so idle ports keep their last address.
  always_comb begin
    va_d[0]    = va_i;
    vb_d[0]    = vb_i;
    addra_d[0] = va_i ? addra_i : addra_q[0];
    addrb_d[0] = vb_i ? addrb_i : addrb_q[0];
    for (int unsigned k = 1; k < Depth; k++) begin
      va_d[k]    = va_q[k-1];
      vb_d[k]    = vb_q[k-1];
      addra_d[k] = va_q[k-1] ? addra_q[k-1] : addra_q[k];
      addrb_d[k] = vb_q[k-1] ? addrb_q[k-1] : addrb_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va_q    <= '0;
      vb_q    <= '0;
      addra_q <= '{default: '0};
      addrb_q <= '{default: '0};
    end else begin
      va_q    <= va_d;
      vb_q    <= vb_d;
      addra_q <= addra_d;
      addrb_q <= addrb_d;
    end
  end

  assign wea_o   = va_q[Depth-1];
  assign web_o   = vb_q[Depth-1];
  assign addra_o = addra_q[Depth-1];
  assign addrb_o = addrb_q[Depth-1];

endmodule

// File: rtl/ys_poly_small_ctrl3.sv
// Mode-3 sequencer: streams RAM1 word pairs to the datapath and aligns RAM2 writes to its output.
module ys_poly_small_ctrl3
  import ys_poly_small_ctrl3_pkg::*;
#(
  parameter int unsigned N       = NtruN,
  parameter int unsigned AW      = DefAw,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned EXE_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          ram1_ena,
  output logic          ram1_enb,
  output logic [AW-1:0] ram1_addra,
  output logic [AW-1:0] ram1_addrb,
  output logic          f_ctr,
  output logic          ram2_wea,
  output logic          ram2_web,
  output logic [AW-1:0] ram2_addra,
  output logic [AW-1:0] ram2_addrb
);

  localparam int unsigned W    = ceil_half(N);
  localparam int unsigned B    = ceil_half(W);
  localparam int unsigned PIPE = RD_LAT + EXE_LAT;

  if (W > (32'd1 << AW)) begin : g_aw_check
    $error("ys_poly_small_ctrl3: W words do not fit in AW address bits");
  end

  state_e              state_q, state_d;
  logic [AW-1:0]       j_q, j_d;
  logic [RD_LAT-1:0]   fdly_q, fdly_d;
  logic                run;
  logic                beat0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      j_q     <= '0;
      fdly_q  <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      fdly_q  <= fdly_d;
    end
  end

  // j counts beats in RUN and is reused as the drain counter in FLUSH.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    fdly_d  = RD_LAT'({fdly_q, beat0});
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          j_d     = '0;
        end
      end
      StRun: begin
        if (j_q == AW'(B - 1)) begin
          state_d = StFlush;
          j_d     = '0;
        end else begin
          j_d = j_q + AW'(1);
        end
      end
      StFlush: begin
        if (j_q == AW'(PIPE - 1)) begin
          state_d = StDone;
          j_d     = '0;
        end else begin
          j_d = j_q + AW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    run        = (state_q == StRun);
    busy       = run || (state_q == StFlush);
    done       = (state_q == StDone);
    beat0      = run && (j_q == '0);
    ram1_ena   = run;
    ram1_enb   = run && ((2 * 32'(j_q) + 1) < W);
    ram1_addra = run ? {j_q[AW-2:0], 1'b0} : '0;
    ram1_addrb = ram1_enb ? {j_q[AW-2:0], 1'b1} : '0;
    f_ctr      = fdly_q[RD_LAT-1];
  end

  ys_poly_small_wpipe #(
    .Depth(PIPE),
    .AW   (AW)
  ) u_wpipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .va_i   (ram1_ena),
    .vb_i   (ram1_enb),
    .addra_i(ram1_addra),
    .addrb_i(ram1_addrb),
    .wea_o  (ram2_wea),
    .web_o  (ram2_web),
    .addra_o(ram2_addra),
    .addrb_o(ram2_addrb)
  );

endmodule

// File: tb/tb_ys_poly_small_ctrl3.sv
// Bench for ys_poly_small_ctrl3: cycle-timing model plus RAM/datapath model with golden results.
module tb_ys_poly_small_ctrl3;

  localparam int N = 509, W = 255, B = 128, RL = 1, PIPE = 2, AW = 8;
  localparam int N2 = 8, W2 = 4, B2 = 2, RL2 = 2, PIPE2 = 3;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, start2 = 1'b0;
  logic busy, done, ram1_ena, ram1_enb, f_ctr, ram2_wea, ram2_web;
  logic [AW-1:0] ram1_addra, ram1_addrb, ram2_addra, ram2_addrb;
  logic busy2, done2, r1a2, r1b2, f2, wa2, wb2;
  logic [AW-1:0] r1aa2, r1ab2, r2aa2, r2ab2;

  int checks = 0, errors = 0;

  logic [12:0] g    [N];
  logic [25:0] mem1 [W];
  logic [25:0] ram2 [W];
  logic [25:0] douta, doutb, dina, dinb;
  logic [12:0] prev;
  bit          dvalid;

  always #5 clk = ~clk;

  ys_poly_small_ctrl3 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .ram1_ena(ram1_ena), .ram1_enb(ram1_enb), .ram1_addra(ram1_addra), .ram1_addrb(ram1_addrb),
    .f_ctr(f_ctr), .ram2_wea(ram2_wea), .ram2_web(ram2_web), .ram2_addra(ram2_addra),
    .ram2_addrb(ram2_addrb)
  );

  ys_poly_small_ctrl3 #(.N(N2), .AW(AW), .RD_LAT(RL2), .EXE_LAT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .ram1_ena(r1a2), .ram1_enb(r1b2), .ram1_addra(r1aa2), .ram1_addrb(r1ab2),
    .f_ctr(f2), .ram2_wea(wa2), .ram2_web(wb2), .ram2_addra(r2aa2), .ram2_addrb(r2ab2)
  );

  typedef struct {
    bit ena, enb, f, wea, web, busy, done;
    int addra, addrb, waddra, waddrb;
  } exp_t;

  // Expected outputs t cycles after the start cycle, derived from beat/latency arithmetic.
  function automatic exp_t expect_at(int t, int b, int w, int rl, int p);
    exp_t e;
    int r, q;
    r = t - 1;
    q = t - 1 - p;
    e.ena    = (r >= 0) && (r < b);
    e.enb    = e.ena && (2 * r + 1 < w);
    e.addra  = 2 * r;
    e.addrb  = 2 * r + 1;
    e.f      = (t == 1 + rl);
    e.wea    = (q >= 0) && (q < b);
    e.web    = e.wea && (2 * q + 1 < w);
    e.waddra = 2 * q;
    e.waddrb = 2 * q + 1;
    e.busy   = (t >= 1) && (t <= b + p);
    e.done   = (t == b + p + 1);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp))
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_main(input string ph, input exp_t e);
    chk({ph, " busy"}, busy, e.busy);
    chk({ph, " done"}, done, e.done);
    chk({ph, " ena"}, ram1_ena, e.ena);
    chk({ph, " enb"}, ram1_enb, e.enb);
    chk({ph, " f_ctr"}, f_ctr, e.f);
    chk({ph, " wea"}, ram2_wea, e.wea);
    chk({ph, " web"}, ram2_web, e.web);
    if (e.ena) chk({ph, " addra"}, ram1_addra, e.addra);
    if (e.enb) chk({ph, " addrb"}, ram1_addrb, e.addrb);
    if (e.wea) chk({ph, " waddra"}, ram2_addra, e.waddra);
    if (e.web) chk({ph, " waddrb"}, ram2_addrb, e.waddrb);
  endtask

  task automatic check_zero(input string ph);
    chk({ph, " busy"}, busy, 0);
    chk({ph, " done"}, done, 0);
    chk({ph, " ena"}, ram1_ena, 0);
    chk({ph, " enb"}, ram1_enb, 0);
    chk({ph, " addra"}, ram1_addra, 0);
    chk({ph, " addrb"}, ram1_addrb, 0);
    chk({ph, " f_ctr"}, f_ctr, 0);
    chk({ph, " wea"}, ram2_wea, 0);
    chk({ph, " web"}, ram2_web, 0);
    chk({ph, " waddra"}, ram2_addra, 0);
    chk({ph, " waddrb"}, ram2_addrb, 0);
  endtask

  // One pass of the default DUT; RAM1, the datapath and RAM2 are modelled cycle by cycle.
  task automatic run_pass(input string ph, input int extra_t, input int abort_t,
                          input bit start_on_done);
    exp_t        e;
    int          nwa, nwb, ndone;
    bit          aborted;
    logic [12:0] c0, c1, c2, c3, o0, expv, got;
    logic [25:0] word;
    for (int i = 0; i < N; i++) g[i] = 13'($urandom);
    for (int w = 0; w < W; w++) begin
      mem1[w] = {(2 * w + 1 < N) ? g[2*w+1] : 13'd0, g[2*w]};
      ram2[w] = 'x;
    end
    douta = '0; doutb = '0; dina = '0; dinb = '0; prev = '0; dvalid = 1'b0;
    nwa = 0; nwb = 0; ndone = 0; aborted = 1'b0;
    for (int t = 0; t <= B + PIPE + 1; t++) begin
      start = (t == 0) || (t == extra_t) || (start_on_done && (t == B + PIPE + 1));
      if (t == abort_t) begin
        rst_n   = 1'b0;
        aborted = 1'b1;
      end
      @(negedge clk);
      if (aborted) begin
        check_zero({ph, " rst"});
        break;
      end
      e = expect_at(t, B, W, RL, PIPE);
      check_main(ph, e);
      if (ram2_wea === 1'b1) begin ram2[ram2_addra] = dina; nwa++; end
      if (ram2_web === 1'b1) begin ram2[ram2_addrb] = dinb; nwb++; end
      if (done === 1'b1) ndone++;
      if (dvalid) begin
        c0 = douta[12:0]; c1 = douta[25:13]; c2 = doutb[12:0]; c3 = doutb[25:13];
        o0 = (f_ctr === 1'b1) ? 13'(-3 * int'(c0)) : 13'(3 * (int'(prev) - int'(c0)));
        dina = {13'(3 * (int'(c0) - int'(c1))), o0};
        dinb = {13'(3 * (int'(c2) - int'(c3))), 13'(3 * (int'(c1) - int'(c2)))};
        prev = c3;
      end
      dvalid = (ram1_ena === 1'b1);
      if (ram1_ena === 1'b1) douta = mem1[ram1_addra];
      if (ram1_enb === 1'b1) doutb = mem1[ram1_addrb];
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    if (!aborted) begin
      chk({ph, " nwrites_a"}, nwa, B);
      chk({ph, " nwrites_b"}, nwb, W - B);
      chk({ph, " ndone"}, ndone, 1);
      for (int i = 0; i < N; i++) begin
        word = ram2[i/2];
        got  = (i % 2 == 1) ? word[25:13] : word[12:0];
        expv = (i == 0) ? 13'(-3 * int'(g[0])) : 13'(3 * (int'(g[i-1]) - int'(g[i])));
        chk($sformatf("%s coeff%0d", ph, i), got, int'(expv));
      end
    end
  endtask

  task automatic run_small();
    exp_t e;
    for (int t = 0; t <= B2 + PIPE2 + 1; t++) begin
      start2 = (t == 0);
      @(negedge clk);
      e = expect_at(t, B2, W2, RL2, PIPE2);
      chk("small busy", busy2, e.busy);
      chk("small done", done2, e.done);
      chk("small ena", r1a2, e.ena);
      chk("small enb", r1b2, e.enb);
      chk("small f_ctr", f2, e.f);
      chk("small wea", wa2, e.wea);
      chk("small web", wb2, e.web);
      if (e.ena) chk("small addra", r1aa2, e.addra);
      if (e.enb) chk("small addrb", r1ab2, e.addrb);
      if (e.wea) chk("small waddra", r2aa2, e.waddra);
      if (e.web) chk("small waddrb", r2ab2, e.waddrb);
      @(posedge clk);
      #1;
    end
    start2 = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_zero("reset");
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;

    run_pass("nominal", -1, -1, 1'b0);
    run_pass("busy_start", 50, -1, 1'b0);

    run_pass("abort", -1, 60, 1'b0);
    for (int k = 61; k <= 64; k++) begin
      @(posedge clk);
      #1;
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_zero("in_reset");
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    for (int k = 65; k <= 69; k++) begin
      @(negedge clk);
      check_zero("post_reset");
      @(posedge clk);
      #1;
    end
    run_pass("restart", -1, -1, 1'b0);

    run_pass("b2b_first", -1, -1, 1'b1);
    run_pass("b2b_second", -1, -1, 1'b0);

    run_small();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
